// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter fed by a small byte FIFO.
// The baud divisor is latched per frame, so divisor changes take effect at the next frame.
module uart_transmitter #(
   parameter int unsigned FifoDepth = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [14:0]                  clks_per_bit_i,
   input  logic                         tx_valid_i,
   input  logic [7:0]                   tx_byte_i,
   output logic                         tx_ready_o,
   output logic                         tx_o,
   output logic                         busy_o,
   output logic                         done_o,
   output logic [$clog2(FifoDepth):0]   fifo_level_o
);

   localparam int unsigned AW = $clog2(FifoDepth);
   localparam logic [AW:0]   LvlFull = (AW+1)'(FifoDepth);
   localparam logic [AW:0]   LvlOne  = (AW+1)'(1);
   localparam logic [AW-1:0] PtrOne  = (AW)'(1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   logic [7:0]    r_mem [FifoDepth];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic [1:0]    r_state;
   logic [14:0]   r_div;
   logic [14:0]   r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_tx;
   logic          r_done;

   logic          w_empty;
   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic          w_expire;
   logic [14:0]   w_div_new;
   logic [7:0]    w_head;

   always_comb begin
      w_empty   = (r_level == '0);
      w_full    = (r_level == LvlFull);
      w_push    = tx_valid_i & ~w_full;
      w_expire  = (r_cnt == r_div - 15'd1);
      // Pop either from IDLE or at the end of a stop bit, giving gapless back-to-back frames
      w_pop     = ~w_empty & ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_expire));
      w_div_new = (clks_per_bit_i == '0) ? 15'd1 : clks_per_bit_i;
      w_head    = r_mem[r_rd_ptr];
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= tx_byte_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PtrOne;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrOne;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LvlOne;
            2'b01:   r_level <= r_level - LvlOne;
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
         r_div   <= '0;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_tx <= 1'b1;
               if (w_pop) begin
                  r_shift <= w_head;
                  r_div   <= w_div_new;
                  r_cnt   <= '0;
                  r_tx    <= 1'b0;
                  r_state <= ST_START;
               end
            end
            ST_START: begin
               if (w_expire) begin
                  r_cnt   <= '0;
                  r_bit   <= '0;
                  r_tx    <= r_shift[0];
                  r_shift <= r_shift >> 1;
                  r_state <= ST_DATA;
               end else begin
                  r_cnt <= r_cnt + 15'd1;
               end
            end
            ST_DATA: begin
               if (w_expire) begin
                  r_cnt <= '0;
                  if (r_bit == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= ST_STOP;
                  end else begin
                     r_bit   <= r_bit + 3'd1;
                     r_tx    <= r_shift[0];
                     r_shift <= r_shift >> 1;
                  end
               end else begin
                  r_cnt <= r_cnt + 15'd1;
               end
            end
            ST_STOP: begin
               if (w_expire) begin
                  r_done <= 1'b1;
                  r_cnt  <= '0;
                  if (w_pop) begin
                     r_shift <= w_head;
                     r_div   <= w_div_new;
                     r_tx    <= 1'b0;
                     r_state <= ST_START;
                  end else begin
                     r_tx    <= 1'b1;
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + 15'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign tx_ready_o   = ~w_full;
   assign tx_o         = r_tx;
   assign busy_o       = (r_state != ST_IDLE);
   assign done_o       = r_done;
   assign fifo_level_o = r_level;

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter FifoDepth, default 4, giving the byte FIFO depth; the value SHALL be a power of two and at least 2.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port clks_per_bit_i, input, 15 bits: baud divisor in clk_i cycles per bit.
REQ-005 SHALL have port tx_valid_i, input, 1 bit: write request for a byte.
REQ-006 SHALL have port tx_byte_i, input, 8 bits: byte to transmit.
REQ-007 SHALL have port tx_ready_o, output, 1 bit: FIFO can accept a byte.
REQ-008 SHALL have port tx_o, output, 1 bit: serial line, registered, idle high.
REQ-009 SHALL have port busy_o, output, 1 bit: a frame is in progress.
REQ-010 SHALL have port done_o, output, 1 bit: one-cycle pulse at frame completion.
REQ-011 SHALL have port fifo_level_o, output, $clog2(FifoDepth)+1 bits: current FIFO occupancy.

Function
REQ-012 SHALL transmit 8N1 frames: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-013 SHALL accept a byte on every cycle with tx_valid_i && tx_ready_o; tx_ready_o SHALL equal !full and SHALL be combinational from occupancy only.
REQ-014 SHALL implement the FIFO with read and write pointers that wrap modulo FifoDepth.
REQ-015 A simultaneous push and pop SHALL leave fifo_level_o unchanged and lose no data.
REQ-016 A push while full SHALL be ignored (tx_ready_o is low) and leave FIFO contents unchanged.
REQ-017 The FSM SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-018 IDLE: when the FIFO is non-empty, SHALL pop the head byte, latch it into the shift register, latch clks_per_bit_i as divisor D, and enter START.
REQ-019 clks_per_bit_i = 0 SHALL be treated as D = 1.
REQ-020 Each of START, the 8 DATA bits and STOP SHALL hold tx_o for exactly D cycles, so a frame is 10*D cycles.
REQ-021 Changing clks_per_bit_i mid-frame SHALL have no effect until the next frame's latch.
REQ-022 DATA SHALL use a 3-bit bit counter; after bit 7 expires the FSM SHALL go to STOP.
REQ-023 At STOP expiry SHALL assert done_o for exactly one cycle.
REQ-024 At STOP expiry, if the FIFO is non-empty, SHALL pop and go directly to START with no idle cycle; otherwise SHALL go to IDLE.
REQ-025 Latency: for a byte handshaken in cycle N into an empty FIFO while IDLE, the pop SHALL occur in cycle N+1 and tx_o SHALL first be 0 in cycle N+2.
REQ-026 busy_o SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-027 tx_o SHALL be 1 whenever in IDLE.

Reset
REQ-028 With rst_ni low at a clock edge, the following cycle SHALL have:
- tx_o = 1, busy_o = 0, done_o = 0;
- fifo_level_o = 0 and tx_ready_o = 1;
- FSM = IDLE, all counters and pointers 0.
REQ-029 A reset asserted mid-frame SHALL abort the frame and flush the FIFO, with no done_o pulse.

Verification
REQ-030 Single byte: D=4, push 0xA5 -> tx_o = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; done_o pulses once after 40 cycles; busy_o is high for exactly 40 cycles.
REQ-031 Back-to-back: D=2, push 0x00 then 0xFF -> frame 2's start bit immediately follows frame 1's stop bit; the done_o pulses are exactly 20 cycles apart.
REQ-032 Full FIFO: FifoDepth=4, D=8, tx_valid_i held high with 6 distinct bytes -> exactly 5 accepted (1 in shifter + 4 queued), tx_ready_o low, fifo_level_o = 4; all 5 bytes are transmitted in order.
REQ-033 Mid-frame reset: D=4, rst_ni low in cycle 15 of a frame with 2 bytes queued -> tx_o = 1 next cycle, fifo_level_o = 0, no done_o, no further frames.
REQ-034 Divisor: set clks_per_bit_i = 0 -> 10-cycle frame; change clks_per_bit_i 3 -> 6 mid-frame -> current frame is 30 cycles and the next frame is 60 cycles.
REQ-035 Push and pop in the same cycle with level = 2 -> level stays 2 and the byte order is preserved.
